cr_isf_cntr_bank: RTL and testbench
===================================

Name: cr_isf_cntr_bank

Overview:
Parametrised bank of wide per-channel event/byte counters with a local register-access slave port. It succeeds the single-counter ISF aggregate-byte counter and sits behind the ring node's local port in any cr_* regfile. It adds N independent channels, coherent 2-word snapshot reads, clear-on-read, freeze, and sticky overflow status. Counter reset and clearing are software-controlled.

Parameters:
N_CHANNELS, 4, number of independent counters (1..16)
N_COUNTER_BITS, 50, counter width (33..64)
N_COUNT_BY_BITS, 4, increment-amount width per channel
N_ADDR_BITS, 12, local address width
BASE_ADDRESS, 12'h100, byte address of CTRL; registers on a 4-byte stride

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
reg_addr  in  N_ADDR_BITS  local byte address
reg_wr_strb  in  1  single-cycle write strobe
reg_wr_data  in  32  write data
reg_rd_strb  in  1  single-cycle read strobe
reg_rd_data  out  32  read data, valid with reg_ack
reg_ack  out  1  access-complete pulse
reg_err_ack  out  1  access-error pulse (in window, illegal access)
count_stb  in  N_CHANNELS  per-channel increment strobe
count_by  in  N_CHANNELS*N_COUNT_BY_BITS  packed amounts, channel i at [i*N_COUNT_BY_BITS +: N_COUNT_BY_BITS]
ovf_any  out  1  OR of sticky overflow bits

Behaviour:
- Reset: all counters, shadows, CTRL, and STATUS = 0. reg_rd_data = 0, reg_ack = 0, reg_err_ack = 0, ovf_any = 0.
- Address map (offset from BASE):
  - 0x0 CTRL: bit0 clear_all (write-1, self-clearing, reads 0); bit1 freeze; bit2 cor_en.
  - 0x4 STATUS: [N_CHANNELS-1:0] sticky overflow bits, write-1-to-clear.
  - 0x8+8*i CNT_i_PART0: low 32 bits.
  - 0xC+8*i CNT_i_PART1: high N_COUNTER_BITS-32 bits, zero-extended.
- Address window is [BASE, BASE+0x8+8*N_CHANNELS). Outside the window: no ack, no err_ack, no state change. Strobes are mutually exclusive; rd and wr asserted together is undefined.
- Access latency: exactly 1 cycle. reg_ack or reg_err_ack pulses one cycle after the strobe, with reg_rd_data registered in the same cycle. reg_rd_data returns 0 on writes and on errors.
- Errors (err_ack, no state change):
  - Write to any CNT register.
  - Read or write to an address in the window that is not 4-byte aligned.
- Counting: when count_stb[i] && !freeze, cnt_i <= cnt_i + count_by_i, using (N_COUNTER_BITS+1)-bit arithmetic.
  - On carry out: cnt wraps modulo 2^N_COUNTER_BITS (see the optional feature) and STATUS[i] sets.
  - count_by = 0 with stb is a no-op, with no overflow.
- Snapshot: a PART0_i read returns cnt_i[31:0] (pre-update value of that cycle) and latches cnt_i[N-1:32] into shadow_i. A PART1_i read returns shadow_i. A PART1 read without a prior PART0 read returns a stale shadow; this is legal.
- Clear-on-read: with cor_en=1, a PART0_i read clears cnt_i after the snapshot. An increment in the same cycle lands: cnt_i <= count_by_i.
- clear_all: zeroes all counters and shadows next cycle. It has priority over any same-cycle increment (that increment is discarded). STATUS is not affected.
- STATUS collisions: a W1C write and a same-cycle overflow on the same bit leave the bit set.
- freeze: counts are discarded; reads and clears still operate.
- ovf_any: registered OR of STATUS, updated the cycle after STATUS changes.
- Asynchronous reset mid-access: the pending ack is dropped and all state returns to reset values.

Optional Feature:
CR_ISF_CNTR_BANK_SAT_EN
- Defined: counters saturate at 2^N_COUNTER_BITS-1 instead of wrapping. STATUS[i] sets on the first clamp.
- Undefined: wrap-around as above.

Decomposition:
- Package cr_isf_cntr_bankPKG holds:
  - Offset constants CTRL_OFS, STATUS_OFS, CNT_BASE_OFS, CNT_STRIDE.
  - CTRL field typedef cntr_bank_ctrl_t (clear_all, freeze, cor_en).
- One natural sub-module: cr_isf_cntr_chan. It is instantiated N_CHANNELS times via generate, holds one counter plus shadow, and handles add, wrap/saturate, overflow, COR, and clear priority.

Test Plan:
- Reset, then read CTRL/STATUS/CNT_0_PART0 -> all return 0, each ack 1 cycle after its strobe, no err_ack.
- Ch1: count_by=4'hF strobed 100 cycles -> PART0_1 reads 32'd1500, PART1_1 reads 0. Ch0/2/3 read 0.
- Preload ch0 near the 32-bit boundary (2^32-2 via counts), then +4 -> PART0 reads 32'd2, PART1 reads 1. Incrementing between the PART0 and PART1 reads leaves PART1 at 1 (shadow coherency).
- N_COUNTER_BITS=34, push ch2 past 2^34-1 -> wraps (no macro) / holds 34'h3FFFFFFFF (with CR_ISF_CNTR_BANK_SAT_EN). STATUS=4'b0100 and ovf_any=1 in both builds. Writing 4 to STATUS clears it unless an overflow coincides.
- cor_en=1, ch3 holds 7, PART0_3 read with a same-cycle count_by=3 -> read returns 7, then a subsequent read returns 3.
- Write clear_all with a same-cycle stb on all channels -> all counters read 0. Write to CNT_0_PART0 or misaligned BASE+0x2 -> err_ack, no change. Access at BASE-4 -> no ack.

Source files
------------

// File: rtl/cr_isf_cntr_bank_pkg.sv
// Shared register offsets and CTRL layout for the cr_isf_cntr_bank counter bank.
package cr_isf_cntr_bank_pkg;

  localparam int unsigned CTRL_OFS     = 0;
  localparam int unsigned STATUS_OFS   = 4;
  localparam int unsigned CNT_BASE_OFS = 8;
  localparam int unsigned CNT_STRIDE   = 8;

  // Bit 0 is clear_all, bit 1 freeze, bit 2 cor_en.
  typedef struct packed {
    logic cor_en;
    logic freeze;
    logic clear_all;
  } cntr_bank_ctrl_t;

endpackage

// File: rtl/cr_isf_cntr_chan.sv
// One wide counter with snapshot shadow, clear-on-read and clear priority.
// CR_ISF_CNTR_BANK_SAT_EN selects saturation instead of wrap on overflow.
module cr_isf_cntr_chan #(
  parameter int N_COUNTER_BITS  = 50,
  parameter int N_COUNT_BY_BITS = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       freeze,
  input  logic                       cor_en,
  input  logic                       stb,
  input  logic [N_COUNT_BY_BITS-1:0] count_by,
  input  logic                       rd_part0,
  output logic [31:0]                cnt_lo,
  output logic [N_COUNTER_BITS-33:0] shadow,
  output logic                       ovf
);

  logic [N_COUNTER_BITS-1:0]  cnt_reg, cnt_next;
  logic [N_COUNTER_BITS-33:0] shadow_reg, shadow_next;
  logic [N_COUNTER_BITS:0]    sum;
  logic                       inc;
  logic                       cor_clr;

  assign inc     = stb && !freeze;
  assign cor_clr = rd_part0 && cor_en;
  assign sum     = {1'b0, cnt_reg} + (N_COUNTER_BITS+1)'(count_by);

  always_comb begin
    cnt_next    = cnt_reg;
    shadow_next = shadow_reg;
    if (rd_part0) shadow_next = cnt_reg[N_COUNTER_BITS-1:32];
    if (cor_clr) cnt_next = '0;
    if (inc) begin
      // A clear-on-read restarts the count from this cycle's increment.
      if (cor_clr) begin
        cnt_next = N_COUNTER_BITS'(count_by);
      end else if (sum[N_COUNTER_BITS]) begin
`ifdef CR_ISF_CNTR_BANK_SAT_EN
        cnt_next = '1;
`else
        cnt_next = sum[N_COUNTER_BITS-1:0];
`endif
      end else begin
        cnt_next = sum[N_COUNTER_BITS-1:0];
      end
    end
    if (clear) begin
      cnt_next    = '0;
      shadow_next = '0;
    end
  end

  assign ovf    = inc && !cor_clr && !clear && sum[N_COUNTER_BITS];
  assign cnt_lo = cnt_reg[31:0];
  assign shadow = shadow_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg    <= '0;
      shadow_reg <= '0;
    end else begin
      cnt_reg    <= cnt_next;
      shadow_reg <= shadow_next;
    end
  end

endmodule

// File: rtl/cr_isf_cntr_bank.sv
// Bank of N_CHANNELS wide counters behind a single-cycle local register port.
// Build with CR_ISF_CNTR_BANK_SAT_EN to make counters saturate rather than wrap.
module cr_isf_cntr_bank
  import cr_isf_cntr_bank_pkg::*;
#(
  parameter int                     N_CHANNELS      = 4,
  parameter int                     N_COUNTER_BITS  = 50,
  parameter int                     N_COUNT_BY_BITS = 4,
  parameter int                     N_ADDR_BITS     = 12,
  parameter logic [N_ADDR_BITS-1:0] BASE_ADDRESS    = 12'h100
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [N_ADDR_BITS-1:0]                reg_addr,
  input  logic                                  reg_wr_strb,
  input  logic [31:0]                           reg_wr_data,
  input  logic                                  reg_rd_strb,
  output logic [31:0]                           reg_rd_data,
  output logic                                  reg_ack,
  output logic                                  reg_err_ack,
  input  logic [N_CHANNELS-1:0]                 count_stb,
  input  logic [N_CHANNELS*N_COUNT_BY_BITS-1:0] count_by,
  output logic                                  ovf_any
);

  localparam int unsigned WIN_BYTES = CNT_BASE_OFS + CNT_STRIDE * N_CHANNELS;

  logic [N_ADDR_BITS:0]       ofs_full;
  logic [N_ADDR_BITS-1:0]     ofs;
  logic [N_ADDR_BITS-4:0]     chan_sel;
  logic                       in_win, access, aligned, is_cnt, err;
  logic                       ok_wr, ok_rd, ctrl_wr, status_wr, clear;
  cntr_bank_ctrl_t            wr_ctrl, ctrl_reg, ctrl_next;
  logic [N_CHANNELS-1:0]      status_reg, status_next, ovf_vec, w1c;
  logic [31:0]                rd_data_reg, rd_data_next;
  logic                       ack_reg, err_reg, ovf_any_reg;
  logic [31:0]                cnt_lo_arr [N_CHANNELS];
  logic [N_COUNTER_BITS-33:0] shadow_arr [N_CHANNELS];
  logic                       unused_bits;

  assign ofs_full = {1'b0, reg_addr} - {1'b0, BASE_ADDRESS};
  assign ofs      = ofs_full[N_ADDR_BITS-1:0];
  assign in_win   = !ofs_full[N_ADDR_BITS] && (ofs_full < (N_ADDR_BITS+1)'(WIN_BYTES));
  assign access   = (reg_rd_strb || reg_wr_strb) && in_win;
  assign aligned  = (ofs[1:0] == 2'b00);
  assign is_cnt   = (ofs >= N_ADDR_BITS'(CNT_BASE_OFS));
  assign err      = access && (!aligned || (reg_wr_strb && is_cnt));
  assign ok_wr    = access && !err && reg_wr_strb;
  assign ok_rd    = access && !err && reg_rd_strb;
  // Counter registers sit on an 8-byte stride: bit 2 picks PART1, bits above pick the channel.
  assign chan_sel  = ofs[N_ADDR_BITS-1:3] - (N_ADDR_BITS-3)'(1);
  assign ctrl_wr   = ok_wr && (ofs == N_ADDR_BITS'(CTRL_OFS));
  assign status_wr = ok_wr && (ofs == N_ADDR_BITS'(STATUS_OFS));
  assign wr_ctrl   = cntr_bank_ctrl_t'(reg_wr_data[2:0]);
  assign clear     = ctrl_wr && wr_ctrl.clear_all;
  assign w1c       = status_wr ? reg_wr_data[N_CHANNELS-1:0] : '0;
  assign unused_bits = &{1'b0, reg_wr_data};

  generate
    for (genvar gi = 0; gi < N_CHANNELS; gi++) begin : g_chan
      cr_isf_cntr_chan #(
        .N_COUNTER_BITS (N_COUNTER_BITS),
        .N_COUNT_BY_BITS(N_COUNT_BY_BITS)
      ) u_chan (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (clear),
        .freeze  (ctrl_reg.freeze),
        .cor_en  (ctrl_reg.cor_en),
        .stb     (count_stb[gi]),
        .count_by(count_by[gi*N_COUNT_BY_BITS +: N_COUNT_BY_BITS]),
        .rd_part0(ok_rd && is_cnt && !ofs[2] && (chan_sel == (N_ADDR_BITS-3)'(gi))),
        .cnt_lo  (cnt_lo_arr[gi]),
        .shadow  (shadow_arr[gi]),
        .ovf     (ovf_vec[gi])
      );
    end
  endgenerate

  always_comb begin
    ctrl_next = ctrl_reg;
    if (ctrl_wr) begin
      ctrl_next           = wr_ctrl;
      ctrl_next.clear_all = 1'b0;
    end
    status_next = (status_reg & ~w1c) | ovf_vec;
  end

  always_comb begin
    rd_data_next = '0;
    if (ok_rd) begin
      if (!is_cnt) begin
        rd_data_next = ofs[2] ? 32'(status_reg) : 32'(ctrl_reg);
      end else begin
        for (int i = 0; i < N_CHANNELS; i++) begin
          if (chan_sel == (N_ADDR_BITS-3)'(i))
            rd_data_next = ofs[2] ? 32'(shadow_arr[i]) : cnt_lo_arr[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_reg    <= '0;
      status_reg  <= '0;
      ovf_any_reg <= 1'b0;
      rd_data_reg <= '0;
      ack_reg     <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      ctrl_reg    <= ctrl_next;
      status_reg  <= status_next;
      ovf_any_reg <= |status_reg;
      rd_data_reg <= rd_data_next;
      ack_reg     <= access && !err;
      err_reg     <= err;
    end
  end

  assign reg_rd_data = rd_data_reg;
  assign reg_ack     = ack_reg;
  assign reg_err_ack = err_reg;
  assign ovf_any     = ovf_any_reg;

endmodule

// File: tb/tb_cr_isf_cntr_bank.sv
// Scoreboard bench for cr_isf_cntr_bank: 34-bit counters, 32-bit increments, 4 channels.
module tb_cr_isf_cntr_bank;

  localparam int NCH = 4;
  localparam int CB  = 34;
  localparam int BYB = 32;
  localparam int AW  = 12;
  localparam logic [AW-1:0] BASE = 12'h100;
`ifdef CR_ISF_CNTR_BANK_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [AW-1:0]     reg_addr = '0;
  logic              reg_wr_strb = 1'b0;
  logic [31:0]       reg_wr_data = '0;
  logic              reg_rd_strb = 1'b0;
  logic [31:0]       reg_rd_data;
  logic              reg_ack, reg_err_ack;
  logic [NCH-1:0]    count_stb = '0;
  logic [NCH*BYB-1:0] count_by = '0;
  logic              ovf_any;

  cr_isf_cntr_bank #(
    .N_CHANNELS(NCH), .N_COUNTER_BITS(CB), .N_COUNT_BY_BITS(BYB),
    .N_ADDR_BITS(AW), .BASE_ADDRESS(BASE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .reg_addr(reg_addr), .reg_wr_strb(reg_wr_strb),
    .reg_wr_data(reg_wr_data), .reg_rd_strb(reg_rd_strb), .reg_rd_data(reg_rd_data),
    .reg_ack(reg_ack), .reg_err_ack(reg_err_ack), .count_stb(count_stb),
    .count_by(count_by), .ovf_any(ovf_any)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
    int unsigned cyc;
  } exp_t;

  exp_t  exp_q [$];
  string name_q [$];
  int    n_chk = 0;
  int    n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per response, and flags responses that never came.
  always @(negedge clk) begin
    if (rst_n) begin
      if (reg_ack || reg_err_ack) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_resp: ack=%0b err_ack=%0b at cycle %0d, expected none",
                   reg_ack, reg_err_ack, cyc);
        end else begin
          exp_t  e;
          string nm;
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          chk({nm, "_resp"}, 64'({reg_ack, reg_err_ack}), 64'({!e.err, e.err}));
          chk({nm, "_data"}, 64'(reg_rd_data), 64'(e.data));
          chk({nm, "_lat"}, 64'(cyc), 64'(e.cyc));
          $display("txn %-14s ack=%0b err=%0b data=0x%08h cyc=%0d", nm, reg_ack, reg_err_ack,
                   reg_rd_data, cyc);
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        exp_t  e;
        string nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        chk({nm, "_missing"}, 64'(0), 64'(1));
      end
    end
  end

  function automatic logic [AW-1:0] p0(input int i);
    return AW'(int'(BASE) + 8 + 8 * i);
  endfunction
  function automatic logic [AW-1:0] p1(input int i);
    return AW'(int'(BASE) + 12 + 8 * i);
  endfunction

  // kind: 0 = no response expected, 1 = ack, 2 = err_ack
  task automatic acc(input string nm, input bit w, input logic [AW-1:0] a, input logic [31:0] d,
                     input logic [NCH-1:0] stb, input logic [31:0] by, input int kind,
                     input logic [31:0] exp);
    exp_t e;
    reg_addr    = a;
    reg_wr_strb = w;
    reg_rd_strb = !w;
    reg_wr_data = d;
    count_stb   = stb;
    count_by    = {NCH{by}};
    if (kind != 0) begin
      e.err  = (kind == 2);
      e.data = exp;
      e.cyc  = cyc + 1;
      exp_q.push_back(e);
      name_q.push_back(nm);
    end
    @(posedge clk); #1;
    reg_wr_strb = 1'b0;
    reg_rd_strb = 1'b0;
    count_stb   = '0;
    count_by    = '0;
  endtask

  task automatic rd(input string nm, input logic [AW-1:0] a, input logic [31:0] exp);
    acc(nm, 1'b0, a, 32'h0, '0, 32'h0, 1, exp);
  endtask
  task automatic wr(input string nm, input logic [AW-1:0] a, input logic [31:0] d);
    acc(nm, 1'b1, a, d, '0, 32'h0, 1, 32'h0);
  endtask

  task automatic cnt(input logic [NCH-1:0] stb, input logic [31:0] by, input int n);
    repeat (n) begin
      count_stb = stb;
      count_by  = {NCH{by}};
      @(posedge clk); #1;
    end
    count_stb = '0;
    count_by  = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #12;
    chk("rst_outputs", 64'({reg_rd_data, reg_ack, reg_err_ack, ovf_any}), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);

    // Reset values
    rd("rst_ctrl", BASE, 32'h0);
    rd("rst_status", BASE + 12'h4, 32'h0);
    rd("rst_p0_0", p0(0), 32'h0);

    // Ch1 100 x 15
    cnt(4'b0010, 32'hF, 100);
    rd("ch1_p0", p0(1), 32'd1500);
    rd("ch1_p1", p1(1), 32'h0);
    rd("ch0_p0", p0(0), 32'h0);
    rd("ch2_p0", p0(2), 32'h0);
    rd("ch3_p0", p0(3), 32'h0);

    // Ch0 across 32-bit boundary, shadow coherency
    cnt(4'b0001, 32'hFFFF_FFFE, 1);
    cnt(4'b0001, 32'h4, 1);
    rd("bnd_p0", p0(0), 32'h2);
    cnt(4'b0001, 32'hFFFF_FFFF, 2);
    rd("bnd_p1_stale", p1(0), 32'h1);
    rd("bnd_p0_b", p0(0), 32'h0);
    rd("bnd_p1_new", p1(0), 32'h3);

    // Ch2 overflow at 2^34
    cnt(4'b0100, 32'hFFFF_FFFF, 4);
    rd("pre_ovf_p0", p0(2), 32'hFFFF_FFFC);
    rd("pre_ovf_p1", p1(2), 32'h3);
    rd("pre_ovf_stat", BASE + 12'h4, 32'h0);
    chk("pre_ovf_any", 64'(ovf_any), 64'(0));
    cnt(4'b0100, 32'h5, 1);
    rd("ovf_stat", BASE + 12'h4, 32'h4);
    rd("ovf_p0", p0(2), SAT ? 32'hFFFF_FFFF : 32'h1);
    rd("ovf_p1", p1(2), SAT ? 32'h3 : 32'h0);
    chk("ovf_any_set", 64'(ovf_any), 64'(1));
    cnt(4'b0100, 32'hFFFF_FFFF, 4);
    acc("w1c_collide", 1'b1, BASE + 12'h4, 32'h4, 4'b0100, 32'h5, 1, 32'h0);
    rd("w1c_coll_stat", BASE + 12'h4, 32'h4);
    wr("w1c_clear", BASE + 12'h4, 32'h4);
    rd("w1c_stat", BASE + 12'h4, 32'h0);
    rd("ovf2_p0", p0(2), SAT ? 32'hFFFF_FFFF : 32'h2);
    idle(2);
    chk("ovf_any_clr", 64'(ovf_any), 64'(0));

    // Clear-on-read
    wr("cor_on", BASE, 32'h4);
    cnt(4'b1000, 32'h7, 1);
    acc("cor_rd1", 1'b0, p0(3), 32'h0, 4'b1000, 32'h3, 1, 32'h7);
    rd("cor_rd2", p0(3), 32'h3);
    rd("cor_rd3", p0(3), 32'h0);
    rd("cor_ctrl", BASE, 32'h4);
    wr("cor_off", BASE, 32'h0);

    // Freeze
    wr("frz_on", BASE, 32'h2);
    cnt(4'b0010, 32'h5, 3);
    rd("frz_p0", p0(1), 32'd1500);
    rd("frz_ctrl", BASE, 32'h2);
    wr("frz_off", BASE, 32'h0);
    cnt(4'b0010, 32'h5, 1);
    rd("unfrz_p0", p0(1), 32'd1505);

    // clear_all beats same-cycle increments
    acc("clr_all", 1'b1, BASE, 32'h1, 4'b1111, 32'h9, 1, 32'h0);
    rd("clr_p1_0", p1(0), 32'h0);
    for (int i = 0; i < NCH; i++) rd($sformatf("clr_p0_%0d", i), p0(i), 32'h0);
    rd("clr_p1_2", p1(2), 32'h0);
    rd("clr_ctrl", BASE, 32'h0);

    // Error and out-of-window accesses
    cnt(4'b0001, 32'h6, 1);
    acc("err_wr_cnt0", 1'b1, p0(0), 32'h1234, '0, 32'h0, 2, 32'h0);
    acc("err_wr_cnt1", 1'b1, p1(0), 32'h1234, '0, 32'h0, 2, 32'h0);
    rd("err_p0_keep", p0(0), 32'h6);
    acc("err_rd_mis", 1'b0, BASE + 12'h2, 32'h0, '0, 32'h0, 2, 32'h0);
    acc("err_wr_mis", 1'b1, BASE + 12'h2, 32'h6, '0, 32'h0, 2, 32'h0);
    rd("err_ctrl", BASE, 32'h0);
    cnt(4'b0001, 32'h1, 1);
    rd("err_p0_cnt", p0(0), 32'h7);
    acc("oow_rd_lo", 1'b0, BASE - 12'h4, 32'h0, '0, 32'h0, 0, 32'h0);
    acc("oow_wr_lo", 1'b1, BASE - 12'h4, 32'h2, '0, 32'h0, 0, 32'h0);
    acc("oow_rd_hi", 1'b0, BASE + 12'h28, 32'h0, '0, 32'h0, 0, 32'h0);
    rd("oow_ctrl", BASE, 32'h0);

    // Asynchronous reset during a pending read
    cnt(4'b0010, 32'h3, 1);
    reg_addr    = p0(1);
    reg_rd_strb = 1'b1;
    @(posedge clk); #2;
    rst_n       = 1'b0;
    reg_rd_strb = 1'b0;
    #1;
    chk("arst_ack", 64'({reg_ack, reg_err_ack}), 64'(0));
    chk("arst_data", 64'(reg_rd_data), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    rd("arst_p0_1", p0(1), 32'h0);
    rd("arst_ctrl", BASE, 32'h0);
    rd("arst_stat", BASE + 12'h4, 32'h0);
    chk("arst_ovf_any", 64'(ovf_any), 64'(0));

    idle(3);
    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
